seven_segment_scanner: RTL and testbench

- Time-multiplexed driver for a 4-digit common-anode seven-segment display with active-low anodes, segments and decimal point.
- Latches four BCD digits plus decimal points from the clock/counter logic into a tear-free frame buffer.
- Scans one digit per refresh slot and inserts a blanking gap between slots to suppress ghosting.
- Sits between the time-keeping core and the board display pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seven_segment_display.sv | 30 +++
 rtl/seven_segment_scanner.sv | 183 ++++++++++++++++++
 tb/tb_seven_segment_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display path.
// Contents: digit count, blank patterns for segments/anodes, BCD nibble and
// segment-pattern typedefs, and a helper that builds an active-low one-hot
// anode enable from a digit index.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  localparam seg_t                  SEG_BLANK = 7'b1111111;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Active-low one-hot anode enable for the given digit.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] a;
    a      = ANODE_OFF;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/seven_segment_display.sv
// BCD to active-low seven-segment glyph decoder (purely combinational).
// Ports:
//   i_bcd      - BCD nibble to display
//   o_segments - active-low segments, bit 6 = g ... bit 0 = a
// Nibbles 10-15 decode to all segments off.
module seven_segment_display
  import seg_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_segments
);

  always_comb begin
    o_segments = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_segments = 7'b1000000;
      4'd1:    o_segments = 7'b1111001;
      4'd2:    o_segments = 7'b0100100;
      4'd3:    o_segments = 7'b0110000;
      4'd4:    o_segments = 7'b0011001;
      4'd5:    o_segments = 7'b0010010;
      4'd6:    o_segments = 7'b0000010;
      4'd7:    o_segments = 7'b1111000;
      4'd8:    o_segments = 7'b0000000;
      4'd9:    o_segments = 7'b0010000;
      default: o_segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Digits are captured into a pending buffer on i_load and promoted to the
// active buffer only at a frame boundary, so a scanned frame never mixes old
// and new digits. Each digit slot lasts REFRESH_DIV cycles and starts with
// BLANK_CYCLES cycles of all-off output to suppress ghosting.
//
// Ports:
//   i_clk         - system clock
//   i_rst_n       - asynchronous active-low reset
//   i_digits_in   - four BCD nibbles, [3:0] = digit 0 (rightmost)
//   i_dp_in       - decimal-point request per digit, 1 = lit
//   i_load        - single-cycle strobe capturing i_digits_in / i_dp_in
//   o_anode       - active-low digit enables
//   o_segments    - active-low segments, bit 6 = g ... bit 0 = a
//   o_dp          - active-low decimal point
//   o_frame_start - one-cycle pulse when the outputs show slot 0, count 0
//
// Build option: define SEVEN_SEG_LZ_BLANK_EN to blank leading zeros on
// digits 3..1 (digit 0 always shown).
module seven_segment_scanner
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [15:0]           i_digits_in,
  input  logic [NUM_DIGITS-1:0] i_dp_in,
  input  logic                  i_load,
  output logic [NUM_DIGITS-1:0] o_anode,
  output seg_t                  o_segments,
  output logic                  o_dp,
  output logic                  o_frame_start
);

  localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam digit_idx_t       IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0] r_cnt;
  digit_idx_t       r_idx;

  // Frame buffers
  logic [15:0]           r_pend_digits;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend_vld;
  logic [15:0]           r_act_digits;
  logic [NUM_DIGITS-1:0] r_act_dp;

  // Output registers
  logic [NUM_DIGITS-1:0] r_anode;
  seg_t                  r_segments;
  logic                  r_dp;
  logic                  r_frame_start;

  // Next-state / combinational signals
  logic                  w_wrap;
  logic                  w_frame_end;
  logic                  w_blank;
  bcd_t                  w_nibble;
  seg_t                  w_seg_dec;
  logic [NUM_DIGITS-1:0] w_lz_sup;

  logic [15:0]           w_pend_digits_nxt;
  logic [NUM_DIGITS-1:0] w_pend_dp_nxt;
  logic                  w_pend_vld_nxt;
  logic [15:0]           w_act_digits_nxt;
  logic [NUM_DIGITS-1:0] w_act_dp_nxt;

  logic [NUM_DIGITS-1:0] w_anode_nxt;
  seg_t                  w_segments_nxt;
  logic                  w_dp_nxt;
  logic                  w_frame_start_nxt;

  assign w_wrap      = (r_cnt == CNT_MAX);
  assign w_frame_end = w_wrap && (r_idx == IDX_LAST);
  assign w_blank     = (r_cnt < BLANK_END);
  assign w_nibble    = r_act_digits[{r_idx, 2'b00} +: 4];

  seven_segment_display u_decoder (
    .i_bcd      (w_nibble),
    .o_segments (w_seg_dec)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // A digit is suppressed when it is zero and every higher digit is zero too.
  logic w_sup3, w_sup2, w_sup1;
  assign w_sup3   = (r_act_digits[15:12] == 4'd0);
  assign w_sup2   = w_sup3 && (r_act_digits[11:8] == 4'd0);
  assign w_sup1   = w_sup2 && (r_act_digits[7:4] == 4'd0);
  assign w_lz_sup = {w_sup3, w_sup2, w_sup1, 1'b0};
`else
  assign w_lz_sup = '0;
`endif

  // Buffer next-state: a load in the boundary cycle bypasses the pending
  // buffer so it is shown in the frame that starts right now.
  always_comb begin
    w_pend_digits_nxt = r_pend_digits;
    w_pend_dp_nxt     = r_pend_dp;
    w_pend_vld_nxt    = r_pend_vld;
    w_act_digits_nxt  = r_act_digits;
    w_act_dp_nxt      = r_act_dp;
    if (w_frame_end) begin
      if (i_load) begin
        w_act_digits_nxt = i_digits_in;
        w_act_dp_nxt     = i_dp_in;
      end else if (r_pend_vld) begin
        w_act_digits_nxt = r_pend_digits;
        w_act_dp_nxt     = r_pend_dp;
      end
      w_pend_vld_nxt = 1'b0;
    end else if (i_load) begin
      w_pend_digits_nxt = i_digits_in;
      w_pend_dp_nxt     = i_dp_in;
      w_pend_vld_nxt    = 1'b1;
    end
  end

  // Output next-state, derived from the current counter/index state.
  always_comb begin
    w_anode_nxt       = ANODE_OFF;
    w_segments_nxt    = SEG_BLANK;
    w_dp_nxt          = 1'b1;
    w_frame_start_nxt = (r_cnt == '0) && (r_idx == '0);
    if (!w_blank && !w_lz_sup[r_idx]) begin
      w_anode_nxt    = anode_sel(r_idx);
      w_segments_nxt = w_seg_dec;
      w_dp_nxt       = ~r_act_dp[r_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + digit_idx_t'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_digits <= '0;
      r_pend_dp     <= '0;
      r_pend_vld    <= 1'b0;
      r_act_digits  <= '0;
      r_act_dp      <= '0;
    end else begin
      r_pend_digits <= w_pend_digits_nxt;
      r_pend_dp     <= w_pend_dp_nxt;
      r_pend_vld    <= w_pend_vld_nxt;
      r_act_digits  <= w_act_digits_nxt;
      r_act_dp      <= w_act_dp_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_anode       <= ANODE_OFF;
      r_segments    <= SEG_BLANK;
      r_dp          <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_anode       <= w_anode_nxt;
      r_segments    <= w_segments_nxt;
      r_dp          <= w_dp_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

  assign o_anode       = r_anode;
  assign o_segments    = r_segments;
  assign o_dp          = r_dp;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (REFRESH_DIV = 8, BLANK_CYCLES = 2).
// Expected per-slot outputs are pushed to a scoreboard queue when a frame's
// content is known and popped when the DUT scans that slot.
module tb_seven_segment_scanner;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = 4 * RDIV;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        load    = 1'b0;
  logic [15:0] digits  = '0;
  logic [3:0]  dpin    = '0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        fs;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .REFRESH_DIV  (RDIV),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_digits_in   (digits),
    .i_dp_in       (dpin),
    .i_load        (load),
    .o_anode       (anode),
    .o_segments    (seg),
    .o_dp          (dp),
    .o_frame_start (fs)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Queue the four visible-slot expectations of a frame showing d / p.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] p);
    logic [3:0] sup;
    exp_t       e;
    sup = '0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    sup[3] = (d[15:12] == 4'd0);
    sup[2] = sup[3] && (d[11:8] == 4'd0);
    sup[1] = sup[2] && (d[7:4] == 4'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      e.an  = sup[k] ? 4'b1111 : ~(4'b0001 << k);
      e.seg = sup[k] ? 7'b1111111 : glyph(d[4*k +: 4]);
      e.dp  = sup[k] ? 1'b1 : ~p[k];
      sb.push_back(e);
    end
  endtask

  // Wait (bounded) for frame_start; optionally check how many cycles it took.
  task automatic wait_frame(input string tag, input int exp_gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (fs !== 1'b1 && n < 2 * FRAME);
    cmp({tag, "_fs_seen"}, 32'(fs), 32'd1);
    if (exp_gap > 0) cmp({tag, "_fs_gap"}, n, exp_gap);
  endtask

  // Called on the negedge where frame_start is high (cycle 0 of a frame).
  // Optionally pulses load on cycles l1c / l2c (-1 = none).
  task automatic check_frame(input string tag,
                             input int l1c, input logic [15:0] d1, input logic [3:0] p1,
                             input int l2c, input logic [15:0] d2, input logic [3:0] p2);
    exp_t cur;
    int   fs_extra;
    fs_extra = 0;
    cur      = '0;
    for (int c = 0; c < int'(FRAME); c++) begin
      if (c > 0) @(negedge clk);
      load = 1'b0;
      if (c == l1c) begin load = 1'b1; digits = d1; dpin = p1; end
      if (c == l2c) begin load = 1'b1; digits = d2; dpin = p2; end
      if (c > 0 && fs === 1'b1) fs_extra++;
      if (c % RDIV == 1)
        cmp($sformatf("%s_blank_s%0d", tag, c / RDIV), 32'(anode), 32'hF);
      if (c % RDIV == BLANK) begin
        cmp($sformatf("%s_sb_avail_s%0d", tag, c / RDIV), 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) cur = sb.pop_front();
        cmp($sformatf("%s_first_s%0d", tag, c / RDIV), 32'({anode, seg, dp}), 32'(cur));
      end
      if (c % RDIV == RDIV - 1)
        cmp($sformatf("%s_last_s%0d", tag, c / RDIV), 32'({anode, seg, dp}), 32'(cur));
    end
    load = 1'b0;
    cmp({tag, "_fs_once"}, fs_extra, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    cmp("reset_out", 32'({anode, seg, dp, fs}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    rst_n = 1'b1;

    // 1: free-running scan of 0000
    wait_frame("t1", 1);
    push_frame(16'h0000, 4'b0000);
    check_frame("t1", -1, '0, '0, -1, '0, '0);

    // 2: mid-frame load does not disturb the current frame
    wait_frame("t2a", 1);
    push_frame(16'h0000, 4'b0000);
    check_frame("t2a", 10, 16'h1234, 4'b0100, -1, '0, '0);

    // 2 shown; 3: two loads within this frame, last one wins
    wait_frame("t2b", 1);
    push_frame(16'h1234, 4'b0100);
    check_frame("t2b", 5, 16'h1111, 4'b0000, 20, 16'h5678, 4'b0000);

    // 3 shown; 4: load in the boundary cycle (last cycle of this frame)
    wait_frame("t3", 1);
    push_frame(16'h5678, 4'b0000);
    check_frame("t3", FRAME - 2, 16'h9999, 4'b0000, -1, '0, '0);

    // 4 shown immediately; 5: invalid nibbles, dp still honoured
    wait_frame("t4", 1);
    push_frame(16'h9999, 4'b0000);
    check_frame("t4", 10, 16'h00FA, 4'b0001, -1, '0, '0);

    wait_frame("t5", 1);
    push_frame(16'h00FA, 4'b0001);
    check_frame("t5", -1, '0, '0, -1, '0, '0);

    // 6: reset during a visible slot with a load pending
    wait_frame("t6", 1);
    repeat (3) @(negedge clk);
    load = 1'b1; digits = 16'h4321; dpin = 4'b1111;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    cmp("t6_pre_anode", 32'(anode), 32'({4'b1101}));
    #1 rst_n = 1'b0;
    #1;
    cmp("t6_async_rst", 32'({anode, seg, dp, fs}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    wait_frame("t6a", 1);
    push_frame(16'h0000, 4'b0000);
    check_frame("t6a", -1, '0, '0, -1, '0, '0);
    wait_frame("t6b", 1);
    push_frame(16'h0000, 4'b0000);
    check_frame("t6b", -1, '0, '0, -1, '0, '0);

    cmp("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
